// File: rtl/reg_bank_arbiter_if.sv
// Requester-side and register-bank-side signals of the arbiter.
// The slave modport is the arbiter; the master modport drives requests and plays the bank.
interface reg_bank_arbiter_if #(
    parameter int REG_W  = 8,
    parameter int ADDR_W = 4
);
    logic              ena;
    logic [1:0]        req;
    logic [1:0]        wr_rdn;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [REG_W-1:0]  wdata0;
    logic [REG_W-1:0]  wdata1;
    logic [REG_W-1:0]  rdata0;
    logic [REG_W-1:0]  rdata1;
    logic [1:0]        done;
    logic [1:0]        err;
    logic              bank_wr_rdn;
    logic [ADDR_W-1:0] bank_addr;
    logic [REG_W-1:0]  bank_wdata;
    logic              bank_we;
    logic [REG_W-1:0]  bank_rdata;
    logic              bank_ack;
    logic              bank_err;

    modport slave (
        input  ena, req, wr_rdn, addr0, addr1, wdata0, wdata1,
        input  bank_rdata, bank_ack, bank_err,
        output rdata0, rdata1, done, err,
        output bank_wr_rdn, bank_addr, bank_wdata, bank_we
    );

    modport master (
        output ena, req, wr_rdn, addr0, addr1, wdata0, wdata1,
        output bank_rdata, bank_ack, bank_err,
        input  rdata0, rdata1, done, err,
        input  bank_wr_rdn, bank_addr, bank_wdata, bank_we
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one register-bank port between SPI (requester 0) and I2C (requester 1).
// Each requester has a one-deep pending slot; accesses are issued one at a time with an ack timeout.
module reg_bank_arbiter #(
    parameter int REG_W   = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input logic               clk,
    input logic               rstb,
    reg_bank_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [1:0]        r_pend;
    logic [1:0]        r_slotWr;
    logic [ADDR_W-1:0] r_slotAddr [2];
    logic [REG_W-1:0]  r_slotWdata [2];
    logic              r_cur;
    logic              r_lastGrant;
    logic [7:0]        r_cnt;
    logic              r_bankWrRdn;
    logic [ADDR_W-1:0] r_bankAddr;
    logic [REG_W-1:0]  r_bankWdata;
    logic [REG_W-1:0]  r_rdata [2];
    logic [1:0]        r_done;
    logic [1:0]        r_err;

    logic              w_timeout;
    logic              w_finish;
    logic              w_owner;
    logic              w_grant;
    logic [1:0]        w_complete;
    logic [1:0]        w_accept;
    logic [1:0]        w_overflow;
    logic [ADDR_W-1:0] w_reqAddr [2];
    logic [REG_W-1:0]  w_reqWdata [2];

    assign w_reqAddr[0]  = bus.addr0;
    assign w_reqAddr[1]  = bus.addr1;
    assign w_reqWdata[0] = bus.wdata0;
    assign w_reqWdata[1] = bus.wdata1;

    // r_cnt is 0 in the first WAIT cycle; the abort is timed so its pulse lands TIMEOUT cycles after bank_we.
    always_comb begin
        w_nextState = r_state;
        w_timeout   = ({1'b0, r_cnt} + 9'd2) >= 9'(TIMEOUT);
        w_finish    = (r_state == WAIT) && (bus.bank_ack || w_timeout);
        w_complete  = w_finish ? (r_cur ? 2'b10 : 2'b01) : 2'b00;
        w_owner     = (r_pend == 2'b11) ? ~r_lastGrant : r_pend[1];
        w_grant     = (r_state == IDLE) && bus.ena && (r_pend != 2'b00);
        w_accept    = {2{bus.ena}} & bus.req & (~r_pend | w_complete);
        w_overflow  = {2{bus.ena}} & bus.req & r_pend & ~w_complete;
        case (r_state)
            IDLE:    if (w_grant) w_nextState = ISSUE;
            ISSUE:   w_nextState = WAIT;
            WAIT:    if (w_finish) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_pend      <= 2'b00;
            r_slotWr    <= 2'b00;
            r_cur       <= 1'b0;
            r_lastGrant <= 1'b1;
            r_cnt       <= '0;
            r_bankWrRdn <= 1'b0;
            r_bankAddr  <= '0;
            r_bankWdata <= '0;
            r_done      <= 2'b00;
            r_err       <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_slotAddr[i]  <= '0;
                r_slotWdata[i] <= '0;
                r_rdata[i]     <= '0;
            end
        end else begin
            r_pend <= (r_pend & ~w_complete) | w_accept;
            for (int i = 0; i < 2; i++) begin
                if (w_accept[i]) begin
                    r_slotWr[i]    <= bus.wr_rdn[i];
                    r_slotAddr[i]  <= w_reqAddr[i];
                    r_slotWdata[i] <= w_reqWdata[i];
                end
            end
            // Bank-side fields are copied at grant so a slot can be refilled while its access finishes.
            if (w_grant) begin
                r_cur       <= w_owner;
                r_bankWrRdn <= r_slotWr[w_owner];
                r_bankAddr  <= r_slotAddr[w_owner];
                r_bankWdata <= r_slotWdata[w_owner];
            end
            if (r_state == ISSUE)     r_cnt <= '0;
            else if (r_state == WAIT) r_cnt <= r_cnt + 8'd1;
            if (w_finish) begin
                r_lastGrant <= r_cur;
                if (bus.bank_ack && !r_bankWrRdn) r_rdata[r_cur] <= bus.bank_rdata;
            end
            r_done <= w_complete;
            r_err  <= (w_complete & {2{~bus.bank_ack | bus.bank_err}}) | w_overflow;
        end
    end

    assign bus.rdata0      = r_rdata[0];
    assign bus.rdata1      = r_rdata[1];
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.bank_we     = (r_state == ISSUE);
    assign bus.bank_wr_rdn = r_bankWrRdn;
    assign bus.bank_addr   = r_bankAddr;
    assign bus.bank_wdata  = r_bankWdata;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: a transaction-level model checked every cycle, directed
// scenarios with hand-computed expectations, then randomized traffic against a modelled bank.
module tb_reg_bank_arbiter;
    localparam int REG_W   = 8;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rstb = 1'b0;

    reg_bank_arbiter_if #(.REG_W(REG_W), .ADDR_W(ADDR_W)) bus ();

    reg_bank_arbiter #(.REG_W(REG_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    bit   randomMode = 1'b0;
    int   fixedDelay = 1;
    int   curDelay   = 1;
    logic [7:0] mem [16];

    // Model state: pending request per requester plus the one access in flight.
    bit         mPend [2];
    bit         mWr [2];
    logic [3:0] mAddr [2];
    logic [7:0] mWdata [2];
    logic [7:0] mRdata [2];
    bit         mBusy;
    int         mSince;
    bit         mCur;
    bit         mLast;
    bit         mBWr;
    logic [3:0] mBAddr;
    logic [7:0] mBWdata;
    bit         mWe;
    logic [1:0] mDone;
    logic [1:0] mErr;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mPend[i] = 0; mWr[i] = 0; mAddr[i] = '0; mWdata[i] = '0; mRdata[i] = '0;
        end
        mBusy = 0; mSince = 0; mCur = 0; mLast = 1;
        mBWr = 0; mBAddr = '0; mBWdata = '0; mWe = 0; mDone = '0; mErr = '0;
    endtask

    // One clock edge worth of behaviour, using the inputs that were present before the edge.
    task automatic modelStep();
        bit         wasPend [2];
        bit         finishing [2];
        bit         w;
        logic [1:0] nd = '0;
        logic [1:0] ne = '0;
        wasPend = mPend;
        finishing[0] = 0; finishing[1] = 0;
        if (mBusy && mSince >= 1 && (bus.bank_ack || mSince >= TIMEOUT - 1)) begin
            finishing[mCur] = 1;
            nd[mCur] = 1'b1;
            ne[mCur] = !bus.bank_ack || bus.bank_err;
            if (bus.bank_ack && !mBWr) mRdata[mCur] = bus.bank_rdata;
            mPend[mCur] = 0;
            mLast = mCur;
            mBusy = 0;
        end else if (mBusy) begin
            mSince++;
        end else if (bus.ena && (mPend[0] || mPend[1])) begin
            if (mPend[0] && mPend[1]) w = !mLast;
            else                      w = mPend[1];
            mBusy = 1; mSince = 0; mCur = w;
            mBWr = mWr[w]; mBAddr = mAddr[w]; mBWdata = mWdata[w];
        end
        for (int i = 0; i < 2; i++) begin
            if (bus.ena && bus.req[i]) begin
                if (wasPend[i] && !finishing[i]) begin
                    ne[i] = 1'b1;
                end else begin
                    mPend[i]  = 1;
                    mWr[i]    = bus.wr_rdn[i];
                    mAddr[i]  = (i == 0) ? bus.addr0 : bus.addr1;
                    mWdata[i] = (i == 0) ? bus.wdata0 : bus.wdata1;
                end
            end
        end
        mDone = nd;
        mErr  = ne;
        mWe   = mBusy && (mSince == 0);
    endtask

    function automatic int pickDelay();
        int r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return TIMEOUT - 1;
        if (r == 2) return TIMEOUT - 2;
        return $urandom_range(1, 4);
    endfunction

    // Compare process plus the register-bank responder, both one step after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rstb) modelReset();
            else       modelStep();
            checkOutput("done", bus.done, mDone);
            checkOutput("err", bus.err, mErr);
            checkOutput("bank_we", bus.bank_we, mWe);
            checkOutput("bank_addr", bus.bank_addr, mBAddr);
            checkOutput("bank_wr_rdn", bus.bank_wr_rdn, mBWr);
            checkOutput("bank_wdata", bus.bank_wdata, mBWdata);
            checkOutput("rdata0", bus.rdata0, mRdata[0]);
            checkOutput("rdata1", bus.rdata1, mRdata[1]);
            bus.bank_ack   = 1'b0;
            bus.bank_err   = 1'b0;
            bus.bank_rdata = 8'($urandom);
            if (rstb) begin
                if (mWe) curDelay = randomMode ? pickDelay() : fixedDelay;
                if (mBusy && mSince >= 1 && mSince == curDelay) begin
                    bit e = randomMode ? ($urandom_range(0, 7) == 0) : (mBWr && mBAddr == 4'd9);
                    bus.bank_ack   = 1'b1;
                    bus.bank_err   = e;
                    bus.bank_rdata = mem[mBAddr];
                    if (mBWr && !e && mBAddr != 4'd9) mem[mBAddr] = mBWdata;
                end else if (randomMode && !(mBusy && mSince >= 1) && $urandom_range(0, 5) == 0) begin
                    bus.bank_ack = 1'b1;
                    bus.bank_err = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic resetDut();
        rstb = 1'b0;
        bus.req = 2'b00;
        stepCycle();
        stepCycle();
        rstb = 1'b1;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] wr, input logic [3:0] a0,
                                 input logic [7:0] d0, input logic [3:0] a1, input logic [7:0] d1);
        bus.req = req; bus.wr_rdn = wr;
        bus.addr0 = a0; bus.wdata0 = d0; bus.addr1 = a1; bus.wdata1 = d1;
    endtask

    int         oWeCyc [$];
    logic [3:0] oWeAddr [$];
    bit         oWeWr [$];
    int         oDone [2];
    logic       oErr [2];

    function automatic int weAt(input int n);
        return (n < oWeCyc.size()) ? oWeCyc[n] : -1;
    endfunction

    // Cycle 1 is the first cycle after the request strobe was sampled.
    task automatic observe(input int limit, input logic [1:0] waitMask);
        logic [1:0] seen = 2'b00;
        oWeCyc.delete(); oWeAddr.delete(); oWeWr.delete();
        oDone[0] = -1; oDone[1] = -1; oErr[0] = 0; oErr[1] = 0;
        for (int k = 1; k <= limit && (seen & waitMask) != waitMask; k++) begin
            stepCycle();
            if (k == 1) bus.req = 2'b00;
            if (bus.bank_we) begin
                oWeCyc.push_back(k); oWeAddr.push_back(bus.bank_addr); oWeWr.push_back(bus.bank_wr_rdn);
            end
            for (int i = 0; i < 2; i++) begin
                if (bus.done[i] && !seen[i]) begin
                    seen[i] = 1'b1; oDone[i] = k; oErr[i] = bus.err[i];
                end
            end
        end
        checkOutput("observeBound", 32'(seen & waitMask), 32'(waitMask));
    endtask

    initial begin
        int         cnt [2];
        logic [3:0] order [$];
        int         d0, d1, weCount, doneCount;

        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
        mem[9] = 8'hA5;
        bus.ena = 1'b1; bus.req = 2'b00; bus.wr_rdn = 2'b00;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.bank_ack = 1'b0; bus.bank_err = 1'b0; bus.bank_rdata = '0;

        resetDut();
        checkOutput("resetDone", bus.done, 2'b00);
        checkOutput("resetBankWe", bus.bank_we, 1'b0);
        checkOutput("resetRdata0", bus.rdata0, 8'h00);

        $display("[TB] single SPI read");
        fixedDelay = 1;
        applyStimulus(2'b01, 2'b00, 4'd9, 8'h00, 4'd0, 8'h00);
        observe(20, 2'b01);
        checkOutput("t1DoneLatency", oDone[0], 4);
        checkOutput("t1WeCycle", weAt(0), 2);
        checkOutput("t1WeCount", oWeCyc.size(), 1);
        checkOutput("t1BankAddr", oWeAddr.size() > 0 ? oWeAddr[0] : 4'hF, 4'd9);
        checkOutput("t1Rdata0", bus.rdata0, 8'hA5);
        checkOutput("t1Err", oErr[0], 1'b0);

        $display("[TB] simultaneous requests");
        resetDut();
        applyStimulus(2'b11, 2'b01, 4'd2, 8'h3C, 4'd2, 8'h00);
        observe(30, 2'b11);
        checkOutput("t2Done0", oDone[0], 4);
        checkOutput("t2Done1", oDone[1], 7);
        checkOutput("t2SecondWe", weAt(1), 5);
        checkOutput("t2FirstIsWrite", oWeWr.size() > 0 ? oWeWr[0] : 1'b0, 1'b1);
        checkOutput("t2Rdata1", bus.rdata1, 8'h3C);

        $display("[TB] fairness");
        resetDut();
        cnt[0] = 1; cnt[1] = 1;
        applyStimulus(2'b11, 2'b00, 4'd3, 8'h00, 4'd4, 8'h00);
        for (int k = 1; k <= 80 && order.size() < 6; k++) begin
            stepCycle();
            bus.req = 2'b00;
            if (bus.bank_we) order.push_back(bus.bank_addr);
            for (int i = 0; i < 2; i++) begin
                if (bus.done[i] && cnt[i] < 3) begin
                    bus.req[i] = 1'b1;
                    cnt[i]++;
                end
            end
        end
        bus.req = 2'b00;
        repeat (10) stepCycle();
        checkOutput("t3GrantCount", order.size(), 6);
        for (int j = 0; j < 6; j++)
            checkOutput($sformatf("t3Grant%0d", j), j < order.size() ? order[j] : 4'hF, (j % 2 == 0) ? 4'd3 : 4'd4);

        $display("[TB] overflow");
        fixedDelay = 6;
        d0 = -1; d1 = -1;
        applyStimulus(2'b01, 2'b00, 4'd7, 8'h00, 4'd0, 8'h00);
        for (int k = 1; k <= 40; k++) begin
            stepCycle();
            bus.req = 2'b00;
            if (k == 3) begin bus.req = 2'b10; bus.addr1 = 4'd5; end
            if (k == 5) begin bus.req = 2'b10; bus.addr1 = 4'd6; end
            if (k == 6) checkOutput("t4OverflowErr", bus.err, 2'b10);
            if (bus.done[0] && d0 < 0) d0 = k;
            if (bus.done[1] && d1 < 0) d1 = k;
        end
        checkOutput("t4Done0", d0, 9);
        checkOutput("t4Done1", d1, 17);
        checkOutput("t4Rdata1", bus.rdata1, 8'h15);

        $display("[TB] timeout");
        fixedDelay = 0;
        applyStimulus(2'b01, 2'b00, 4'd8, 8'h00, 4'd0, 8'h00);
        observe(40, 2'b01);
        checkOutput("t5TimeoutGap", oDone[0] - weAt(0), TIMEOUT);
        checkOutput("t5TimeoutErr", oErr[0], 1'b1);
        checkOutput("t5Rdata0Held", bus.rdata0, 8'h17);
        fixedDelay = 1;
        applyStimulus(2'b10, 2'b00, 4'd0, 8'h00, 4'd4, 8'h00);
        observe(20, 2'b10);
        checkOutput("t5NextDone", oDone[1], 4);
        checkOutput("t5NextRdata1", bus.rdata1, 8'h14);

        $display("[TB] ena low");
        bus.ena = 1'b0;
        weCount = 0;
        applyStimulus(2'b01, 2'b00, 4'd1, 8'h00, 4'd0, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            stepCycle();
            bus.req = 2'b00;
            if (k == 5) bus.ena = 1'b1;
            if (bus.bank_we) weCount++;
        end
        checkOutput("t6NoIssue", weCount, 0);

        $display("[TB] reset during wait");
        fixedDelay = 10;
        applyStimulus(2'b01, 2'b00, 4'd3, 8'h00, 4'd0, 8'h00);
        stepCycle();
        bus.req = 2'b00;
        stepCycle();
        stepCycle();
        rstb = 1'b0;
        #1;
        checkOutput("t7RstDone", bus.done, 2'b00);
        checkOutput("t7RstBankWe", bus.bank_we, 1'b0);
        checkOutput("t7RstBankAddr", bus.bank_addr, 4'd0);
        checkOutput("t7RstRdata0", bus.rdata0, 8'h00);
        checkOutput("t7RstRdata1", bus.rdata1, 8'h00);
        stepCycle();
        stepCycle();
        rstb = 1'b1;
        weCount = 0; doneCount = 0;
        for (int k = 1; k <= 15; k++) begin
            stepCycle();
            if (bus.bank_we) weCount++;
            if (bus.done != 2'b00) doneCount++;
        end
        checkOutput("t7NoDoneAfter", doneCount, 0);
        checkOutput("t7NoIssueAfter", weCount, 0);

        $display("[TB] random traffic");
        randomMode = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            stepCycle();
            bus.req[0] = ($urandom_range(0, 3) == 0);
            bus.req[1] = ($urandom_range(0, 3) == 0);
            bus.wr_rdn = 2'($urandom);
            bus.addr0  = 4'($urandom);
            bus.addr1  = 4'($urandom);
            bus.wdata0 = 8'($urandom);
            bus.wdata1 = 8'($urandom);
            bus.ena    = ($urandom_range(0, 9) != 0);
        end
        bus.req = 2'b00;
        bus.ena = 1'b1;
        repeat (60) stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares the single register-bank access port between the SPI peripheral (requester 0) and the I2C peripheral (requester 1).
- Replaces the static peripheral-select mux with a dynamic arbiter.
- Buffers one pending access per requester, grants round-robin, and issues one access at a time.
- Waits for the bank's ack, bounded by a timeout, then returns read data, done and error status to the originator.

Parameters:
- REG_W, 8, data width of register accesses.
- ADDR_W, 4, register-bank address width.
- TIMEOUT, 15, max cycles in WAIT before the access is aborted with error; 1..255.

Ports:
- clk  in  1  system clock.
- rstb  in  1  asynchronous active-low reset.
- ena  in  1  block enable; 0 blocks new captures and grants.
- req  in  2  per-requester single-cycle access strobe; bit0 SPI, bit1 I2C.
- wr_rdn  in  2  per-requester direction; 1 = write.
- addr0, addr1  in  ADDR_W each  requester addresses.
- wdata0, wdata1  in  REG_W each  requester write data.
- rdata0, rdata1  out  REG_W each  last read result per requester.
- done  out  2  per-requester single-cycle completion pulse.
- err  out  2  per-requester single-cycle error pulse.
- bank_wr_rdn  out  1  direction to register bank.
- bank_addr  out  ADDR_W  address to register bank.
- bank_wdata  out  REG_W  write data to register bank.
- bank_we  out  1  single-cycle access strobe to register bank.
- bank_rdata  in  REG_W  register-bank read data.
- bank_ack  in  1  register-bank access acknowledge.
- bank_err  in  1  register-bank error; valid with bank_ack.

Behaviour:
- Reset (async, rstb=0): FSM=IDLE; pend=00; all outputs 0; rdata0/1=0; last_grant=1, so SPI wins the first tie; timeout counter=0.
- Capture:
  - On a clk edge with ena=1 and req[i]=1, latch wr_rdn[i], addr_i and wdata_i into slot i and set pend[i].
  - If pend[i] is already set and slot i is not completing that cycle, the new request is dropped and err[i] pulses the next cycle (overflow).
  - If slot i completes and captures a new request on the same edge, the new request is kept and pend[i] stays 1.
- FSM IDLE:
  - If ena=1 and pend!=00, select owner: a single pending slot wins.
  - If both are pending, the winner is ~last_grant.
  - Then move to ISSUE and set cur=owner.
- FSM ISSUE (exactly 1 cycle):
  - bank_we=1; bank_addr, bank_wr_rdn and bank_wdata come from slot cur.
  - Clear the timeout counter; go to WAIT.
- FSM WAIT:
  - bank_we=0; bank_addr, bank_wr_rdn and bank_wdata hold.
  - Counter increments each cycle.
  - On bank_ack=1:
    - if slot cur is a read, rdata_cur <= bank_rdata;
    - done[cur] pulses next cycle; err[cur] pulses with it if bank_err=1;
    - clear pend[cur]; last_grant <= cur; go to IDLE.
  - If the counter reaches TIMEOUT without ack:
    - done[cur] and err[cur] pulse; rdata unchanged;
    - clear pend[cur]; last_grant <= cur; go to IDLE.
  - bank_ack in the same cycle as the timeout is treated as ack.
- bank_ack outside WAIT is ignored.
- ena=0: no captures and no IDLE->ISSUE; an access already in ISSUE/WAIT runs to completion.
- rdata_i holds until the next successful read by requester i.
- Latency, req edge to done, with bank_ack returned one cycle after bank_we: 4 cycles.
  - T0: capture.
  - T1: ISSUE.
  - T2: WAIT, ack.
  - T3: done visible.
- Back-to-back throughput: one access per 3 cycles.
- Mid-operation reset: immediate return to reset state; the pending access is lost with no done pulse.

Test Plan:
- Single SPI read: ro register at addr 9 = 0xA5, req=01, wr_rdn=0, addr0=9 -> bank_we one cycle with bank_addr=9, bank_wr_rdn=0; done[0] 4 cycles after req; rdata0=0xA5; err=00.
- Simultaneous: req=11 at reset, SPI write addr 2 = 0x3C, I2C read addr 2 -> SPI issued first; I2C issued 3 cycles later; rdata1=0x3C; done[0] precedes done[1] by 3 cycles.
- Fairness: both requesters re-request immediately after every done for 6 accesses -> grants alternate 0,1,0,1,0,1.
- Overflow: I2C holds pend while SPI is in WAIT; second req[1] arrives -> err[1] pulses one cycle later; the original I2C access still completes with correct data.
- Timeout: TIMEOUT=15 and bank_ack held 0 -> done[0] and err[0] pulse 15 cycles after bank_we; rdata0 unchanged; a following I2C request is then serviced.
- ena/reset: ena=0 with req=01 -> no bank_we. Reset asserted during WAIT -> all outputs 0 immediately; no done pulse after release.
